cache_ctrl: RTL and testbench

- Controller FSM for the direct-mapped, write-back, write-allocate data cache.
- Sits between the CPU load/store stage and main memory.
- Resolves hit/miss, stalls the CPU on a miss, and sequences dirty-block writeback and block refill over the mem_ready word handshake.
- Owns the tag, valid and dirty state. Drives control for the external data array; it never carries data.

---
 rtl/cache_pkg.sv | 27 ++
 rtl/cache_ctrl_if.sv | 36 +++
 rtl/cache_tag_store.sv | 42 ++++
 rtl/cache_ctrl.sv | 149 ++++++++++++++
 tb/tb_cache_ctrl.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared types, default geometry and address-field helpers for the data-cache controller.
package cache_pkg;

  localparam int CACHE_ADDR_W   = 32;
  localparam int CACHE_INDEX_W  = 3;
  localparam int CACHE_OFFSET_W = 2;
  localparam int CACHE_TAG_W    = CACHE_ADDR_W - CACHE_INDEX_W - CACHE_OFFSET_W - 2;

  typedef enum logic [1:0] {
    COMPARE   = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  function automatic logic [CACHE_TAG_W-1:0] addr_tag(input logic [CACHE_ADDR_W-1:0] a);
    return a[CACHE_ADDR_W-1 -: CACHE_TAG_W];
  endfunction

  function automatic logic [CACHE_INDEX_W-1:0] addr_index(input logic [CACHE_ADDR_W-1:0] a);
    return a[CACHE_OFFSET_W+2 +: CACHE_INDEX_W];
  endfunction

  function automatic logic [CACHE_OFFSET_W-1:0] addr_offset(input logic [CACHE_ADDR_W-1:0] a);
    return a[2 +: CACHE_OFFSET_W];
  endfunction

endpackage

// File: rtl/cache_ctrl_if.sv
// CPU, memory and data-array control signals of the cache controller, bundled as one bus.
interface cache_ctrl_if
  import cache_pkg::*;
#(
  parameter int ADDR_W   = CACHE_ADDR_W,
  parameter int INDEX_W  = CACHE_INDEX_W,
  parameter int OFFSET_W = CACHE_OFFSET_W
);
  logic                cpu_rd;
  logic                cpu_wr;
  logic [ADDR_W-1:0]   cpu_addr;
  logic                cpu_stall;
  logic                hit;
  logic                dary_we;
  logic                dary_sel;
  logic [INDEX_W-1:0]  dary_index;
  logic [OFFSET_W-1:0] dary_offset;
  logic                mem_rd;
  logic                mem_wr;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_ready;

  // Environment side: CPU requests and memory acknowledge.
  modport master (
    output cpu_rd, cpu_wr, cpu_addr, mem_ready,
    input  cpu_stall, hit, dary_we, dary_sel, dary_index, dary_offset,
           mem_rd, mem_wr, mem_addr
  );

  // Controller side.
  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, mem_ready,
    output cpu_stall, hit, dary_we, dary_sel, dary_index, dary_offset,
           mem_rd, mem_wr, mem_addr
  );
endinterface

// File: rtl/cache_tag_store.sv
// Per-line tag, valid and dirty state: combinational read, clocked write, async clear of valid/dirty.
module cache_tag_store #(
  parameter int INDEX_W = 3,
  parameter int TAG_W   = 25
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] index,
  output logic [TAG_W-1:0]   rd_tag,
  output logic               rd_valid,
  output logic               rd_dirty,
  input  logic               fill_en,
  input  logic [TAG_W-1:0]   fill_tag,
  input  logic               dirty_set
);
  localparam int LINES = 1 << INDEX_W;

  logic [TAG_W-1:0] tags [LINES];
  logic [LINES-1:0] valid;
  logic [LINES-1:0] dirty;

  assign rd_tag   = tags[index];
  assign rd_valid = valid[index];
  assign rd_dirty = dirty[index];

  always_ff @(posedge clk) begin
    if (fill_en) tags[index] <= fill_tag;
  end

  // A completed refill always leaves the line clean, even if a store is pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill_en) begin
      valid[index] <= 1'b1;
      dirty[index] <= 1'b0;
    end else if (dirty_set) begin
      dirty[index] <= 1'b1;
    end
  end
endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped write-back/write-allocate cache controller FSM.
// Optional hit/miss statistics counters are built when CACHE_STATS_EN is defined.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W   = CACHE_ADDR_W,
  parameter int INDEX_W  = CACHE_INDEX_W,
  parameter int OFFSET_W = CACHE_OFFSET_W
) (
  input  logic         clk,
  input  logic         rst,
  cache_ctrl_if.slave  bus
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W - 2;

  state_t              state, state_nxt;
  logic [OFFSET_W-1:0] cnt, cnt_nxt;
  logic [TAG_W-1:0]    tag, st_tag;
  logic [INDEX_W-1:0]  idx;
  logic [OFFSET_W-1:0] off;
  logic                st_valid, st_dirty;
  logic                req, lookup_hit, last;
  logic                fill_en, dirty_set;

  assign tag        = addr_tag(bus.cpu_addr);
  assign idx        = addr_index(bus.cpu_addr);
  assign off        = addr_offset(bus.cpu_addr);
  assign req        = bus.cpu_rd | bus.cpu_wr;
  assign lookup_hit = st_valid & (st_tag == tag);
  assign last       = (cnt == {OFFSET_W{1'b1}});

  cache_tag_store #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_tags (
    .clk      (clk),
    .rst      (rst),
    .index    (idx),
    .rd_tag   (st_tag),
    .rd_valid (st_valid),
    .rd_dirty (st_dirty),
    .fill_en  (fill_en),
    .fill_tag (tag),
    .dirty_set(dirty_set)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= COMPARE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Outputs are forced low while reset is asserted so a burst drops immediately.
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    fill_en         = 1'b0;
    dirty_set       = 1'b0;
    bus.cpu_stall   = 1'b0;
    bus.hit         = 1'b0;
    bus.dary_we     = 1'b0;
    bus.dary_sel    = 1'b0;
    bus.dary_index  = '0;
    bus.dary_offset = '0;
    bus.mem_rd      = 1'b0;
    bus.mem_wr      = 1'b0;
    bus.mem_addr    = '0;
    if (!rst) begin
      unique case (state)
        COMPARE: begin
          if (req) begin
            bus.hit = lookup_hit;
            if (lookup_hit) begin
              bus.dary_index  = idx;
              bus.dary_offset = off;
              if (bus.cpu_wr) begin
                bus.dary_we = 1'b1;
                dirty_set   = 1'b1;
              end
            end else begin
              bus.cpu_stall = 1'b1;
              cnt_nxt       = '0;
              state_nxt     = (st_valid & st_dirty) ? WRITEBACK : ALLOCATE;
            end
          end
        end
        WRITEBACK: begin
          bus.cpu_stall   = 1'b1;
          bus.mem_wr      = 1'b1;
          bus.mem_addr    = {st_tag, idx, cnt, 2'b00};
          bus.dary_index  = idx;
          bus.dary_offset = cnt;
          if (bus.mem_ready) begin
            cnt_nxt = cnt + 1'b1;
            if (last) state_nxt = ALLOCATE;
          end
        end
        ALLOCATE: begin
          bus.cpu_stall  = 1'b1;
          bus.mem_rd     = 1'b1;
          bus.mem_addr   = {tag, idx, cnt, 2'b00};
          bus.dary_index = idx;
          if (bus.mem_ready) begin
            bus.dary_we     = 1'b1;
            bus.dary_sel    = 1'b1;
            bus.dary_offset = cnt;
            cnt_nxt         = cnt + 1'b1;
            if (last) begin
              fill_en   = 1'b1;
              state_nxt = COMPARE;
            end
          end
        end
        default: state_nxt = COMPARE;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // refilled marks the re-compare cycle right after a refill so it is not counted again.
  logic refilled;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refilled   <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (fill_en)               refilled <= 1'b1;
      else if (state == COMPARE) refilled <= 1'b0;
      if (state == COMPARE && req && !refilled) begin
        if (lookup_hit) hit_count  <= sat_inc(hit_count);
        else            miss_count <= sat_inc(miss_count);
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed self-checking bench for cache_ctrl; checks hit/miss counters too when CACHE_STATS_EN is defined.
module tb_cache_ctrl;
  import cache_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_ctrl_if bus ();
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  cache_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef CACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  int          n_pass  = 0;
  int          n_total = 0;
  int          both_hi = 0;
  logic [31:0] rd_q[$];
  logic [31:0] wr_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic rdy);
    @(negedge clk);
    bus.cpu_rd    = rd;
    bus.cpu_wr    = wr;
    bus.cpu_addr  = a;
    bus.mem_ready = rdy;
    #1;
  endtask

  // Hold a request with mem_ready high until the stall clears; log memory word addresses.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a, output int stalls);
    rd_q.delete();
    wr_q.delete();
    stalls = 0;
    drive(rd, wr, a, 1'b1);
    while (bus.cpu_stall && stalls < 40) begin
      if (bus.mem_rd && bus.mem_wr) both_hi++;
      if (bus.mem_rd) rd_q.push_back(bus.mem_addr);
      if (bus.mem_wr) wr_q.push_back(bus.mem_addr);
      stalls++;
      drive(rd, wr, a, 1'b1);
    end
  endtask

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  int stalls;

  initial begin
    rst           = 1'b1;
    bus.cpu_rd    = 1'b0;
    bus.cpu_wr    = 1'b0;
    bus.cpu_addr  = '0;
    bus.mem_ready = 1'b0;

    // Reset state
    @(negedge clk);
    #1;
    check("rst_stall", 32'(bus.cpu_stall), 32'd0);
    check("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
    check("rst_state", 32'(dut.state), 32'(COMPARE));
    check("rst_valid", 32'(dut.u_tags.valid), 32'd0);
`ifdef CACHE_STATS_EN
    check("rst_hit_count", hit_count, 32'd0);
    check("rst_miss_count", miss_count, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Test 1: clean miss at 0x40 (index 4, tag 0)
    access(1'b1, 1'b0, 32'h0000_0040, stalls);
    check("t1_stalls", 32'(stalls), 32'd5);
    check("t1_rd_count", 32'(rd_q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t1_rd_addr%0d", i), q_at(rd_q, i), 32'h40 + 32'(4 * i));
    check("t1_hit", 32'(bus.hit), 32'd1);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    check("idle_hit", 32'(bus.hit), 32'd0);

    // Test 2: store hit at 0x44 marks line 4 dirty
    drive(1'b0, 1'b1, 32'h0000_0044, 1'b0);
    check("t2_hit", 32'(bus.hit), 32'd1);
    check("t2_stall", 32'(bus.cpu_stall), 32'd0);
    check("t2_we", 32'(bus.dary_we), 32'd1);
    check("t2_sel", 32'(bus.dary_sel), 32'd0);
    check("t2_index", 32'(bus.dary_index), 32'd4);
    check("t2_offset", 32'(bus.dary_offset), 32'd1);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    check("t2_dirty4", 32'(dut.u_tags.dirty[4]), 32'd1);

    // Test 3: dirty miss at 0x440 (index 4, tag 8)
    access(1'b1, 1'b0, 32'h0000_0440, stalls);
    check("t3_stalls", 32'(stalls), 32'd9);
    check("t3_wr_count", 32'(wr_q.size()), 32'd4);
    check("t3_rd_count", 32'(rd_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_wr_addr%0d", i), q_at(wr_q, i), 32'h40 + 32'(4 * i));
      check($sformatf("t3_rd_addr%0d", i), q_at(rd_q, i), 32'h440 + 32'(4 * i));
    end
    check("t3_hit", 32'(bus.hit), 32'd1);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    check("t3_dirty4", 32'(dut.u_tags.dirty[4]), 32'd0);
`ifdef CACHE_STATS_EN
    check("t6_hit_count", hit_count, 32'd1);
    check("t6_miss_count", miss_count, 32'd2);
`endif

    // Test 4: allocate at 0x80 with ready pattern 1,0,0,1,0,1,1
    drive(1'b1, 1'b0, 32'h0000_0080, 1'b0);
    check("t4_cmp_stall", 32'(bus.cpu_stall), 32'd1);
    check("t4_cmp_mem_rd", 32'(bus.mem_rd), 32'd0);
    drive(1'b1, 1'b0, 32'h0000_0080, 1'b1);
    check("t4_a0_addr", bus.mem_addr, 32'h80);
    check("t4_a0_we", 32'(bus.dary_we), 32'd1);
    check("t4_a0_sel", 32'(bus.dary_sel), 32'd1);
    check("t4_a0_off", 32'(bus.dary_offset), 32'd0);
    drive(1'b1, 1'b0, 32'h0000_0080, 1'b0);
    check("t4_w1_addr", bus.mem_addr, 32'h84);
    check("t4_w1_we", 32'(bus.dary_we), 32'd0);
    drive(1'b1, 1'b0, 32'h0000_0080, 1'b0);
    check("t4_w2_addr", bus.mem_addr, 32'h84);
    drive(1'b1, 1'b0, 32'h0000_0080, 1'b1);
    check("t4_a1_addr", bus.mem_addr, 32'h84);
    check("t4_a1_off", 32'(bus.dary_offset), 32'd1);
    drive(1'b1, 1'b0, 32'h0000_0080, 1'b0);
    check("t4_w3_addr", bus.mem_addr, 32'h88);
    drive(1'b1, 1'b0, 32'h0000_0080, 1'b1);
    check("t4_a2_off", 32'(bus.dary_offset), 32'd2);
    drive(1'b1, 1'b0, 32'h0000_0080, 1'b1);
    check("t4_a3_addr", bus.mem_addr, 32'h8C);
    check("t4_a3_off", 32'(bus.dary_offset), 32'd3);
    drive(1'b1, 1'b0, 32'h0000_0080, 1'b1);
    check("t4_hit", 32'(bus.hit), 32'd1);
    check("t4_stall", 32'(bus.cpu_stall), 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b0);

    // Test 5: reset on the second allocate word at 0x100
    drive(1'b1, 1'b0, 32'h0000_0100, 1'b1);
    drive(1'b1, 1'b0, 32'h0000_0100, 1'b1);
    check("t5_a0_addr", bus.mem_addr, 32'h100);
    drive(1'b1, 1'b0, 32'h0000_0100, 1'b1);
    check("t5_a1_mem_rd", 32'(bus.mem_rd), 32'd1);
    check("t5_a1_addr", bus.mem_addr, 32'h104);
    rst = 1'b1;
    #1;
    check("t5_rst_mem_rd", 32'(bus.mem_rd), 32'd0);
    check("t5_rst_stall", 32'(bus.cpu_stall), 32'd0);
    check("t5_rst_state", 32'(dut.state), 32'(COMPARE));
    check("t5_rst_valid", 32'(dut.u_tags.valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.cpu_rd = 1'b0;
    access(1'b1, 1'b0, 32'h0000_0100, stalls);
    check("t5_reread_stalls", 32'(stalls), 32'd5);
    check("t5_reread_addr0", q_at(rd_q, 0), 32'h100);
    drive(1'b0, 1'b0, 32'h0, 1'b0);

    check("never_rd_and_wr", 32'(both_hi), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
